// File: rtl/ldpc_parity_sched.sv
// Column/beat scheduler for the LDPC parity encoder: it steps the datapath through
// the message columns, the gap columns, a flush, and the second-half accumulation.
module ldpc_parity_sched #(
    parameter int GAP_COLS = 4,
    parameter int COL_W    = 5,
    parameter int LEN_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [COL_W-1:0] max_col_count,
    input  logic [LEN_W-1:0] second_half_len,
    input  logic             cw_vector_valid,
    input  logic             gap_eval_done,
    input  logic             first_half_pc_eval_done,
    output logic [COL_W-1:0] current_col,
    output logic [COL_W-1:0] max_col_count_q,
    output logic             pc_first_half_eval_en,
    output logic             pc_second_half_eval_en,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {
        IDLE, MSG_MUL, GAP_WAIT, GAP_MUL, FLUSH, SECOND_HALF, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] second_half_len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic             gap_rdy;

    // One extra bit so that max_col_count_q + GAP_COLS cannot wrap.
    logic [COL_W:0] col_ext, max_ext, gap_end;
    logic           beat, msg_last, gap_last, sh_last;

    assign col_ext  = {1'b0, current_col};
    assign max_ext  = {1'b0, max_col_count_q};
    assign gap_end  = max_ext + (COL_W+1)'(GAP_COLS);
    assign beat     = pc_first_half_eval_en | pc_second_half_eval_en;
    assign msg_last = col_ext == max_ext - (COL_W+1)'(1);
    assign gap_last = col_ext == gap_end - (COL_W+1)'(1);
    assign sh_last  = (beat_cnt + LEN_W'(1)) == second_half_len_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (start) state_nxt = (max_col_count == '0) ? GAP_WAIT : MSG_MUL;
            MSG_MUL:     if (beat && msg_last) state_nxt = GAP_WAIT;
            GAP_WAIT:    if (gap_rdy || gap_eval_done) state_nxt = GAP_MUL;
            GAP_MUL:     if (beat && gap_last) state_nxt = FLUSH;
            FLUSH:       if (first_half_pc_eval_done)
                             state_nxt = (second_half_len_q == '0) ? DONE : SECOND_HALF;
            SECOND_HALF: if (beat && sh_last) state_nxt = DONE;
            DONE:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy                   = state != IDLE;
        done                   = state == DONE;
        pc_first_half_eval_en  = cw_vector_valid && (state == MSG_MUL || state == GAP_MUL);
        pc_second_half_eval_en = cw_vector_valid && (state == SECOND_HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_col       <= '0;
            max_col_count_q   <= '0;
            second_half_len_q <= '0;
            beat_cnt          <= '0;
            gap_rdy           <= 1'b0;
        end else begin
            // Sticky so an early gap_eval_done is not lost before GAP_WAIT is reached.
            if (state == IDLE || state == DONE) gap_rdy <= 1'b0;
            else if (gap_eval_done)             gap_rdy <= 1'b1;

            case (state)
                IDLE: if (start) begin
                    max_col_count_q   <= max_col_count;
                    second_half_len_q <= second_half_len;
                    current_col       <= '0;
                end
                MSG_MUL, GAP_MUL: if (beat) current_col <= current_col + COL_W'(1);
                FLUSH: if (first_half_pc_eval_done) begin
                    current_col <= '0;
                    beat_cnt    <= '0;
                end
                SECOND_HALF: if (beat) begin
                    current_col <= current_col + COL_W'(1);
                    beat_cnt    <= beat_cnt + LEN_W'(1);
                end
                DONE: current_col <= '0;
                default: ;
            endcase
        end
    end
endmodule
